// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared 640x480 timing constants used by the VGA timing generator and the
//   sink-side sync monitor, plus the monitor's lock-state encoding.
//   No ports (package).
package vga_pkg;

  // Clocks per line, hsync fall to hsync fall (generator counter runs 0..800).
  localparam int VGA_H_TOTAL     = 801;
  localparam int VGA_H_PULSE     = 96;
  // Line position of active pixel x=0 (pulse + back porch).
  localparam int VGA_H_START     = 144;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_START     = 35;
  localparam int VGA_V_ACTIVE    = 480;
  // Consecutive error-free complete frames needed before declaring lock.
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge
//   Input register for one sync line plus fall/rise detection against the
//   previous registered sample.
// Ports:
//   clk       in   pixel clock
//   rst       in   asynchronous active-low reset
//   sync_in   in   raw sync from the port (active low)
//   sync_cur  out  registered sync sample
//   fall      out  previous sample 1, current sample 0
//   rise      out  previous sample 0, current sample 1
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic sync_cur,
  output logic fall,
  output logic rise
);

  logic sync_prev;

  // Both stages reset to the idle (high) level so leaving reset with the
  // line idle produces no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_cur  <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_cur  <= sync_in;
      sync_prev <= sync_cur;
    end
  end

  assign fall = sync_prev & ~sync_cur;
  assign rise = ~sync_prev & sync_cur;

endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Sink-side checker / capture front end for a VGA stream. Measures line and
//   frame timing, declares lock after consecutive good frames, and recovers
//   active-area pixel coordinates with aligned data once locked.
//   Pipeline: stage 1 registers the ports, stage 2 holds position counters and
//   measurement events, stage 3 drives every output from registers. A sample
//   present at edge n shows up on the outputs at edge n+2. There is no
//   backpressure: the output is a continuous stream qualified by pix_valid.
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous active-low reset
//   h_sync       in   horizontal sync, active low
//   v_sync       in   vertical sync, active low
//   vga_data     in   24-bit RGB pixel data
//   pix_x        out  recovered active column (0 when not valid)
//   pix_y        out  recovered active row (0 when not valid)
//   pix_data     out  data sampled at the reported position
//   pix_valid    out  in-area pixel while locked
//   frame_start  out  pulse with pix_valid at x=0, y=0
//   line_len     out  last measured line length
//   frame_lines  out  last measured frame line count
//   locked       out  timing lock
//   err          out  one-cycle pulse per timing violation cycle
//   lock_state   out  lock FSM state (debug)
module vga_sync_monitor
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_PULSE     = VGA_H_PULSE,
  parameter int H_START     = VGA_H_START,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_START     = VGA_V_START,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [23:0] vga_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        err,
  output logic [1:0]  lock_state
);

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] H_PULSE_W = 11'(H_PULSE);
  localparam logic [10:0] H_START_W = 11'(H_START);
  localparam logic [10:0] H_END_W   = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  H_START_X = 10'(H_START);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [9:0]  V_START_W = 10'(V_START);
  localparam logic [9:0]  V_END_W   = 10'(V_START + V_ACTIVE);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);
  localparam logic [10:0] HC_MAX    = 11'h7FF;

  // ---------------- stage 1: port registers and edge detect ----------------
  logic        h_cur, h_fall, h_rise;
  logic        v_fall;
  logic        v_level_unused, v_rise_unused;
  logic [23:0] data_s1;

  vga_sync_edge u_hsync_edge (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (h_sync),
    .sync_cur (h_cur),
    .fall     (h_fall),
    .rise     (h_rise)
  );

  vga_sync_edge u_vsync_edge (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (v_sync),
    .sync_cur (v_level_unused),
    .fall     (v_fall),
    .rise     (v_rise_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_s1 <= '0;
    else      data_s1 <= vga_data;
  end

  // ---------------- stage 2: counters and measurement events ---------------
  // hc/vc hold the position of the sample now in stage 2 (data_s2).
  logic [10:0] hc, hw, h_len;
  logic [9:0]  vc, v_len;
  logic [23:0] data_s2;
  logic        h_seen, v_seen, h_meas, v_meas, v_fall_d;
  logic        e_line, e_frame, e_pulse, e_timeout;
  logic [10:0] hc_plus1, hc_inc, hw_inc;
  logic [9:0]  vc_plus1;

  always_comb begin
    hc_plus1 = hc + 11'd1;
    hc_inc   = (hc == HC_MAX) ? hc : hc_plus1;
    hw_inc   = (hw == HC_MAX) ? hw : hw + 11'd1;
    vc_plus1 = vc + 10'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc        <= '0;
      vc        <= '0;
      hw        <= '0;
      h_len     <= '0;
      v_len     <= '0;
      data_s2   <= '0;
      h_seen    <= 1'b0;
      v_seen    <= 1'b0;
      h_meas    <= 1'b0;
      v_meas    <= 1'b0;
      v_fall_d  <= 1'b0;
      e_line    <= 1'b0;
      e_frame   <= 1'b0;
      e_pulse   <= 1'b0;
      e_timeout <= 1'b0;
    end else begin
      data_s2  <= data_s1;
      v_fall_d <= v_fall;

      hc <= h_fall ? 11'd0 : hc_inc;
      // Flag only the step onto 2047 so a stuck line gives a single pulse.
      e_timeout <= !h_fall && (hc == HC_MAX - 11'd1);

      // Vsync fall wins over a simultaneous hsync fall.
      if (v_fall)      vc <= '0;
      else if (h_fall) vc <= vc_plus1;

      // hw counts low samples before the current one, so on a rise it holds
      // the completed pulse width. Gated on h_seen so a pulse already in
      // progress at reset release is not judged.
      hw      <= h_cur ? 11'd0 : hw_inc;
      e_pulse <= h_rise && h_seen && (hw != H_PULSE_W);

      if (h_fall) h_seen <= 1'b1;
      h_meas <= h_fall && h_seen;
      h_len  <= hc_plus1;
      e_line <= h_fall && h_seen && (hc_plus1 != H_TOTAL_W);

      if (v_fall) v_seen <= 1'b1;
      v_meas  <= v_fall && v_seen;
      v_len   <= vc_plus1;
      e_frame <= v_fall && v_seen && (vc_plus1 != V_TOTAL_W);
    end
  end

  // ---------------- lock FSM ------------------------------------------------
  lock_state_t state, state_next;
  logic [3:0]  good, good_next;
  logic        any_err;

  assign any_err    = e_line | e_frame | e_pulse | e_timeout;
  assign lock_state = state;

  always_comb begin
    state_next = state;
    good_next  = good;
    case (state)
      UNLOCKED: begin
        if (v_fall_d) begin
          state_next = CHECK;
          good_next  = '0;
        end
      end
      CHECK: begin
        // Any error leaves CHECK at once, so reaching a vsync fall here means
        // the frame that just ended was clean.
        if (any_err) begin
          state_next = UNLOCKED;
          good_next  = '0;
        end else if (v_fall_d) begin
          if (good + 4'd1 >= LOCK_W) begin
            state_next = LOCKED;
            good_next  = '0;
          end else begin
            good_next = good + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_next = UNLOCKED;
          good_next  = '0;
        end
      end
      default: begin
        state_next = UNLOCKED;
        good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNLOCKED;
      good  <= '0;
    end else begin
      state <= state_next;
      good  <= good_next;
    end
  end

  // ---------------- stage 3: registered outputs -----------------------------
  logic in_area, valid_next;

  always_comb begin
    in_area    = (hc >= H_START_W) && (hc < H_END_W) &&
                 (vc >= V_START_W) && (vc < V_END_W);
    // Uses the next lock state so pix_valid and locked change on the same edge.
    valid_next = (state_next == LOCKED) && in_area;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      pix_valid   <= valid_next;
      pix_x       <= valid_next ? (hc[9:0] - H_START_X) : 10'd0;
      pix_y       <= valid_next ? (vc - V_START_W) : 10'd0;
      pix_data    <= data_s2;
      frame_start <= valid_next && (hc == H_START_W) && (vc == V_START_W);
      locked      <= (state_next == LOCKED);
      err         <= any_err;
      if (h_meas) line_len    <= h_len;
      if (v_meas) frame_lines <= v_len;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor
//   Directed bench for vga_sync_monitor using a reduced timing set so whole
//   frames are short: 20 clocks/line, 3-clock hsync, active x at 5..14,
//   12 lines/frame, 2-line vsync, active rows at lines 2..7.
//   Pixel data is {4'h0, line[9:0], position[9:0]}.
module tb_vga_sync_monitor;

  localparam int H_TOTAL  = 20;
  localparam int H_PULSE  = 3;
  localparam int H_START  = 5;
  localparam int H_ACTIVE = 10;
  localparam int V_TOTAL  = 12;
  localparam int V_START  = 2;
  localparam int V_ACTIVE = 6;
  localparam int V_PULSE  = 2;

  // ---------------- clock / reset -------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [23:0] vga_data = 24'hABCDEF;
  logic [9:0]  pix_x, pix_y, frame_lines;
  logic [23:0] pix_data;
  logic        pix_valid, frame_start, locked, err;
  logic [10:0] line_len;
  logic [1:0]  lock_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vga_sync_monitor #(
    .H_TOTAL(H_TOTAL), .H_PULSE(H_PULSE), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_START(V_START), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .vga_data(vga_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .err(err), .lock_state(lock_state)
  );

  // ---------------- monitor (collects events for the directed checks) ------
  int          err_cnt, valid_cnt, fs_cnt, bad_data, max_x, max_y;
  int          err_edge, lock_edge, unlock_edge, fs_edge;
  logic [10:0] err_line_len;
  logic [9:0]  fs_x, fs_y;
  logic [23:0] fs_data;
  logic        locked_q = 1'b0;
  logic [23:0] exp_px;

  task automatic clear_stats();
    err_cnt = 0; valid_cnt = 0; fs_cnt = 0; bad_data = 0; max_x = 0; max_y = 0;
    err_edge = -1; lock_edge = -1; unlock_edge = -1; fs_edge = -1;
  endtask

  always @(negedge clk) begin
    if (err) begin
      err_cnt++;
      err_edge = cyc;
      err_line_len = line_len;
    end
    if (locked && !locked_q) lock_edge = cyc;
    if (!locked && locked_q) unlock_edge = cyc;
    locked_q = locked;
    if (pix_valid) begin
      valid_cnt++;
      exp_px = {4'h0, 10'(int'(pix_y) + V_START), 10'(int'(pix_x) + H_START)};
      if (pix_data !== exp_px) bad_data++;
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
    end
    if (frame_start) begin
      fs_cnt++;
      fs_edge = cyc;
      fs_x = pix_x;
      fs_y = pix_y;
      fs_data = pix_data;
    end
  end

  // ---------------- checking -------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------------------------------------
  int vfall_edge, last_hfall_edge, short_mark, wide_mark, px0_edge;

  task automatic drive_px(input logic h, input logic v, input logic [23:0] d);
    @(negedge clk);
    h_sync = h;
    v_sync = v;
    vga_data = d;
  endtask

  // Drives lines first..last of a frame; short_line is one clock shorter,
  // wide_line has a one-clock wider hsync pulse (-1 disables either).
  task automatic drive_lines(input int first, input int last,
                             input int short_line, input int wide_line);
    for (int l = first; l <= last; l++) begin
      int len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
      int pw  = (l == wide_line) ? H_PULSE + 1 : H_PULSE;
      for (int p = 0; p < len; p++) begin
        drive_px(p >= pw, l >= V_PULSE, {4'h0, 10'(l), 10'(p)});
        if (p == 0) begin
          last_hfall_edge = cyc + 1;
          if (l == 0) vfall_edge = cyc + 1;
          if (short_line >= 0 && l == short_line + 1) short_mark = cyc + 1;
        end
        if (l == wide_line && p == pw) wide_mark = cyc + 1;
        if (l == V_START && p == H_START) px0_edge = cyc + 1;
      end
    end
  endtask

  task automatic drive_frame();
    drive_lines(0, V_TOTAL - 1, -1, -1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_pix_valid"},   32'(pix_valid),   0);
    chk({tag, "_pix_x"},       32'(pix_x),       0);
    chk({tag, "_pix_y"},       32'(pix_y),       0);
    chk({tag, "_pix_data"},    32'(pix_data),    0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_line_len"},    32'(line_len),    0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
    chk({tag, "_locked"},      32'(locked),      0);
    chk({tag, "_err"},         32'(err),         0);
    chk({tag, "_lock_state"},  32'(lock_state),  0);
  endtask

  // ---------------- directed sequence -----------------------------------------
  initial begin
    clear_stats();

    // Reset with non-zero data on the port: everything must read 0.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // Clean stream: lock after the 3rd vsync fall, no errors.
    clear_stats();
    drive_frame();
    drive_frame();
    drive_frame();
    chk("lock_latency", 32'(lock_edge), 32'(vfall_edge + 2));
    chk("clean_err_cnt", 32'(err_cnt), 0);
    chk("line_len", 32'(line_len), 20);
    chk("frame_lines", 32'(frame_lines), 12);
    chk("locked_state", 32'(lock_state), 2);
    chk("valid_per_frame", 32'(valid_cnt), 60);
    chk("frame_start_cnt", 32'(fs_cnt), 1);
    chk("frame_start_latency", 32'(fs_edge), 32'(px0_edge + 2));
    chk("fs_x", 32'(fs_x), 0);
    chk("fs_y", 32'(fs_y), 0);
    chk("fs_data", 32'(fs_data), 32'h000805);
    chk("max_x", 32'(max_x), 9);
    chk("max_y", 32'(max_y), 5);
    chk("pix_data_align", 32'(bad_data), 0);

    // Locked frame with line 5 one clock short: error at the next hsync fall.
    clear_stats();
    drive_lines(0, V_TOTAL - 1, 5, -1);
    chk("short_err_cnt", 32'(err_cnt), 1);
    chk("short_err_edge", 32'(err_edge), 32'(short_mark + 2));
    chk("short_line_len", 32'(err_line_len), 19);
    chk("short_unlock_edge", 32'(unlock_edge), 32'(short_mark + 2));
    chk("short_unlocked", 32'(locked), 0);

    // Relock: partial frame ended above, then two clean frames.
    clear_stats();
    drive_frame();
    drive_frame();
    chk("relock_not_yet", 32'(locked), 0);
    drive_frame();
    chk("relock_edge", 32'(lock_edge), 32'(vfall_edge + 2));
    chk("relock_err_cnt", 32'(err_cnt), 0);

    // Hsync pulse widened to 4 on line 3: error on the rise, unlock.
    clear_stats();
    drive_lines(0, V_TOTAL - 1, -1, 3);
    chk("wide_err_cnt", 32'(err_cnt), 1);
    chk("wide_err_edge", 32'(err_edge), 32'(wide_mark + 2));
    chk("wide_unlock_edge", 32'(unlock_edge), 32'(wide_mark + 2));

    // Relock, then hold both syncs high: hc saturates, one timeout error.
    drive_frame();
    drive_frame();
    drive_frame();
    chk("pre_timeout_locked", 32'(locked), 1);
    clear_stats();
    for (int i = 0; i < 2100; i++) drive_px(1'b1, 1'b1, 24'h123456);
    chk("timeout_err_cnt", 32'(err_cnt), 1);
    chk("timeout_err_edge", 32'(err_edge), 32'(last_hfall_edge + 2049));
    chk("timeout_unlock_edge", 32'(unlock_edge), 32'(err_edge));
    chk("timeout_no_valid", 32'(valid_cnt), 0);
    chk("timeout_unlocked", 32'(locked), 0);

    // Recovery: first line after the stall measures 2047+1 wrapped to 0,
    // which is the only error; lock returns after the usual three falls.
    clear_stats();
    drive_frame();
    drive_frame();
    drive_frame();
    chk("recover_err_cnt", 32'(err_cnt), 1);
    chk("recover_lock_edge", 32'(lock_edge), 32'(vfall_edge + 2));

    // Mid-frame asynchronous reset while locked, during an active pixel.
    drive_lines(0, 3, -1, -1);
    for (int p = 0; p < 8; p++) drive_px(p >= H_PULSE, 1'b1, {4'h0, 10'd4, 10'(p)});
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(pix_valid), 1);
    chk("pre_reset_x", 32'(pix_x), 0);
    chk("pre_reset_y", 32'(pix_y), 2);
    #1 rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (3) drive_px(1'b1, 1'b1, 24'h0);
    rst = 1'b1;
    clear_stats();
    drive_lines(5, V_TOTAL - 1, -1, -1);
    drive_frame();
    drive_frame();
    chk("post_reset_not_locked", 32'(locked), 0);
    chk("post_reset_check_state", 32'(lock_state), 1);
    drive_frame();
    chk("post_reset_lock_edge", 32'(lock_edge), 32'(vfall_edge + 2));
    chk("post_reset_err_cnt", 32'(err_cnt), 0);
    chk("post_reset_frame_lines", 32'(frame_lines), 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

- Sink-side companion to the VGA timing generator. Samples H_SYNC, V_SYNC and 24-bit pixel data on the pixel clock.
- Measures line and frame timing against expected parameters and declares lock after consecutive good frames.
- Once locked, recovers active-area pixel coordinates with aligned data.
- Used in-system and in simulation as a checker on the display output path, and as the capture front end for the frame-grab/debug path.

## Interface
- H_TOTAL, 801: expected clocks per line, hsync fall to hsync fall. The timing generator's counter runs 0..800.
- H_PULSE, 96: expected hsync low width in clocks.
- H_START, 144: line position of active pixel x=0 (pulse + back porch).
- H_ACTIVE, 640: active pixels per line.
- V_TOTAL, 525: expected lines per frame.
- V_START, 35: line index of active row y=0.
- V_ACTIVE, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive error-free complete frames required for lock.
- clk  in  1  pixel clock. Same clock as the generator's vga_clk.
- rst  in  1  asynchronous, active-low reset.
- h_sync  in  1  horizontal sync, active low.
- v_sync  in  1  vertical sync, active low.
- vga_data  in  24  RGB pixel data.
- pix_x  out  10  recovered active column, 0..H_ACTIVE-1.
- pix_y  out  10  recovered active row, 0..V_ACTIVE-1.
- pix_data  out  24  data aligned with pix_x/pix_y.
- pix_valid  out  1  high for in-area pixels while locked.
- frame_start  out  1  one-cycle pulse with pix_valid at x=0, y=0.
- line_len  out  11  last measured line length.
- frame_lines  out  10  last measured frame line count.
- locked  out  1  timing lock.
- err  out  1  one-cycle pulse on any timing violation.

## Operation
- Stage 1: register h_sync, v_sync and vga_data, plus previous sync values. A fall is previous=1, current=0.
- Position counter hc (11 bit):
  - 0 on the sample where hsync fall is detected; +1 otherwise.
  - Saturates at 2047. Reaching 2047 is a timeout error.
- Line counter vc (10 bit):
  - +1 on each hsync fall.
  - 0 on vsync fall. Vsync fall has priority over a simultaneous hsync fall.
- Hsync width counter counts consecutive low samples. On hsync rise, compare it to H_PULSE.
- On hsync fall, after a previous fall has been seen since reset:
  - line_len <= hc+1.
  - Error if line_len != H_TOTAL.
- On vsync fall, after a previous vsync fall has been seen:
  - frame_lines <= vc+1.
  - Error if frame_lines != V_TOTAL.
- Lock FSM:
  - UNLOCKED: first vsync fall -> CHECK with good=0.
  - CHECK: each vsync fall with no error in the ending frame gives good+1. When good reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: stays until error.
  - Any error in CHECK or LOCKED -> UNLOCKED and clears good.
- err pulses for every violation in any state, one pulse per violation cycle.
- pix_valid = locked && H_START<=hc<H_START+H_ACTIVE && V_START<=vc<V_START+V_ACTIVE.
- pix_x = hc-H_START and pix_y = vc-V_START, 10-bit truncated. Both are 0 when not valid.
- Reset, including mid-frame: all outputs 0, counters 0, FSM UNLOCKED, seen-fall flags cleared. Measurement restarts from the next falls.

## Timing
- Latency: a sample on the input ports at edge n appears on pix_*/frame_start at edge n+2. Outputs are fully registered.
- line_len, frame_lines, locked and err update 2 cycles after the corresponding sync edge appears on the ports.
- pix_data is always the vga_data sampled at the same position as the reported coordinates.
- No backpressure. Output is a continuous stream qualified by pix_valid.

## Structure
- Shared package vga_pkg holds the 640x480 timing constants, also used by the timing generator.
- Shared package also holds the lock-state enum: UNLOCKED, CHECK, LOCKED.
- One sub-module, vga_sync_edge: input register plus fall/rise detection. Instantiated twice, once per sync.

## Test plan
- Clean 640x480 stream from the generator, LOCK_FRAMES=2 -> locked rises 2 clocks after the 3rd vsync fall. err never pulses. line_len=801, frame_lines=525.
- Locked, data = {y,x} pattern -> pixel at line 35, position 144 gives pix_x=0, pix_y=0, frame_start=1, and matching pix_data 2 clocks later. 640x480 valid pixels per frame.
- Locked, one line shortened to 800 clocks -> err pulse, locked drops at that hsync fall. Relock after 2 further clean frames.
- Hsync pulse widened to 97 -> err on the rise, unlock.
- Syncs held high -> hc saturates at 2047, err, unlocked. pix_valid stays 0.
- rst asserted mid-frame while locked -> all outputs 0 immediately. After release, locked only after first vsync fall plus 2 clean frames.
